// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_seq
// Brief    : Streams operand pairs through an external DSP48A1 slice as a
//            multiply-accumulate job and captures the accumulated result.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_seq #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [17:0]      IN_A,
    input  logic [17:0]      IN_B,
    output logic             BUSY,
    output logic [47:0]      RESULT,
    output logic             RESULT_VALID,
    output logic             OVF,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [17:0]      DSP_D,
    output logic [47:0]      DSP_C,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P,
    input  logic             DSP_CARRYOUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]       c_Z_ZERO     = 2'b00;
    localparam logic [1:0]       c_Z_P        = 2'b10;
    localparam logic [1:0]       c_X_ZERO     = 2'b00;
    localparam logic [1:0]       c_X_M        = 2'b01;
    localparam logic [2:0]       c_OPM_MID    = 3'b000;
    localparam logic [1:0]       c_DRAIN_LAST = 2'd2;
    localparam logic [LEN_W-1:0] c_LEN_ONE    = LEN_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_drain_cnt;
    logic             r_sub;
    logic             r_zero_job;
    logic             r_first_pend;
    logic             w_start;
    logic             w_handshake;
    logic             w_last;

    // Slot pipeline: stage 1 marks the cycle the pair sits on DSP_A/DSP_B,
    // stage 2 drives the matching OPMODE one cycle later.
    logic             r_slot_act;
    logic             r_slot_pair;
    logic             r_slot_first;
    logic [17:0]      r_dsp_a;
    logic [17:0]      r_dsp_b;
    logic [7:0]       r_opmode;
    logic [7:0]       w_opmode_nxt;

    logic [3:0]       r_first_dly;
    logic             r_ovf_win;
    logic             w_ovf_en;
    logic             r_ovf;
    logic [47:0]      r_result;
    logic             r_result_valid;
    logic [1:0]       r_dsp_rst_sr;

    assign w_start     = (r_state == S_IDLE) && START;
    assign w_handshake = (r_state == S_RUN) && IN_VALID;
    assign w_last      = w_handshake && (r_remaining == c_LEN_ONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        IN_READY    = 1'b0;
        BUSY        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = (LEN == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                BUSY = 1'b1;
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                BUSY        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_remaining  <= '0;
            r_sub        <= 1'b0;
            r_zero_job   <= 1'b0;
            r_first_pend <= 1'b0;
            r_drain_cnt  <= 2'd0;
        end else begin
            if (w_start) begin
                r_remaining  <= LEN;
                r_sub        <= SUB;
                r_zero_job   <= (LEN == '0);
                r_first_pend <= 1'b1;
            end else if (w_handshake) begin
                r_remaining  <= r_remaining - c_LEN_ONE;
                r_first_pend <= 1'b0;
            end
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_slot_act   <= 1'b0;
            r_slot_pair  <= 1'b0;
            r_slot_first <= 1'b0;
            r_dsp_a      <= 18'd0;
            r_dsp_b      <= 18'd0;
            r_opmode     <= 8'h00;
        end else begin
            r_slot_act   <= (r_state == S_RUN);
            r_slot_pair  <= w_handshake;
            r_slot_first <= w_handshake && r_first_pend;
            if (w_handshake) begin
                r_dsp_a <= IN_A;
                r_dsp_b <= IN_B;
            end
            r_opmode <= w_opmode_nxt;
        end
    end

    // The first pair restarts the accumulator from zero; bubbles hold P.
    always_comb begin
        w_opmode_nxt = 8'h00;
        if (r_slot_act) begin
            if (r_slot_first) begin
                w_opmode_nxt = {r_sub, c_OPM_MID, c_Z_ZERO, c_X_M};
            end else if (r_slot_pair) begin
                w_opmode_nxt = {r_sub, c_OPM_MID, c_Z_P, c_X_M};
            end else begin
                w_opmode_nxt = {r_sub, c_OPM_MID, c_Z_P, c_X_ZERO};
            end
        end
    end

    // Carry-out becomes meaningful four cycles after the first acceptance,
    // when the first product has reached the P register.
    assign w_ovf_en = r_first_dly[3] || r_ovf_win;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_first_dly <= 4'd0;
            r_ovf_win   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_first_dly <= {r_first_dly[2:0], w_handshake && r_first_pend};
            if (w_start || (r_state == S_DONE)) begin
                r_ovf_win <= 1'b0;
            end else if (r_first_dly[3]) begin
                r_ovf_win <= 1'b1;
            end
            if (w_start) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_en) begin
                r_ovf <= r_ovf || DSP_CARRYOUT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_result       <= 48'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_result <= r_zero_job ? 48'd0 : DSP_P;
            end
        end
    end

    // Hold the DSP in reset through the first full cycle after release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dsp_rst_sr <= 2'b11;
        end else begin
            r_dsp_rst_sr <= {r_dsp_rst_sr[0], 1'b0};
        end
    end

    assign RESULT       = r_result;
    assign RESULT_VALID = r_result_valid;
    assign OVF          = r_ovf;
    assign DSP_A        = r_dsp_a;
    assign DSP_B        = r_dsp_b;
    assign DSP_D        = 18'd0;
    assign DSP_C        = 48'd0;
    assign DSP_OPMODE   = r_opmode;
    assign DSP_CE       = BUSY;
    assign DSP_RST      = r_dsp_rst_sr[1];

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_seq
// Brief    : Self-checking bench for dsp_mac_seq with a DSP48A1 slice model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_seq;

    localparam int LEN_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             START;
    logic [LEN_W-1:0] LEN;
    logic             SUB;
    logic             IN_VALID;
    logic             IN_READY;
    logic [17:0]      IN_A;
    logic [17:0]      IN_B;
    logic             BUSY;
    logic [47:0]      RESULT;
    logic             RESULT_VALID;
    logic             OVF;
    logic [17:0]      DSP_A;
    logic [17:0]      DSP_B;
    logic [17:0]      DSP_D;
    logic [47:0]      DSP_C;
    logic [7:0]       DSP_OPMODE;
    logic             DSP_CE;
    logic             DSP_RST;
    logic [47:0]      DSP_P;
    logic             DSP_CARRYOUT;

    dsp_mac_seq #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .SUB(SUB),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .BUSY(BUSY), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .OVF(OVF),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_C(DSP_C),
        .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE), .DSP_RST(DSP_RST),
        .DSP_P(DSP_P), .DSP_CARRYOUT(DSP_CARRYOUT)
    );

    always #5 CLK = ~CLK;

    // DSP48A1 slice: A1/B1, M, OPMODE, P and CARRYOUT registers, sync reset.
    logic [17:0] m_a1, m_b1;
    logic [35:0] m_m;
    logic [7:0]  m_opm;
    logic [47:0] m_p;
    logic        m_co;
    always @(posedge CLK) begin : dsp_model
        logic [47:0] x, z;
        logic [48:0] s;
        if (DSP_RST) begin
            m_a1 <= '0; m_b1 <= '0; m_m <= '0; m_opm <= '0; m_p <= '0; m_co <= 1'b0;
        end else if (DSP_CE) begin
            case (m_opm[1:0])
                2'b00:   x = 48'd0;
                2'b01:   x = {12'd0, m_m};
                2'b10:   x = m_p;
                default: x = {DSP_D[11:0], m_a1, m_b1};
            endcase
            case (m_opm[3:2])
                2'b10:   z = m_p;
                2'b11:   z = DSP_C;
                default: z = 48'd0;
            endcase
            if (m_opm[7]) s = {1'b0, z} - ({1'b0, x} + 49'(m_opm[5]));
            else          s = {1'b0, z} + {1'b0, x} + 49'(m_opm[5]);
            m_p  <= s[47:0];
            m_co <= s[48];
            m_a1 <= DSP_A;
            m_b1 <= DSP_B;
            m_m  <= 36'(m_a1) * 36'(m_b1);
            m_opm <= DSP_OPMODE;
        end
    end
    assign DSP_P        = m_p;
    assign DSP_CARRYOUT = m_co;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    int rv_total = 0;
    always @(negedge CLK) if (RESULT_VALID) rv_total <= rv_total + 1;

    int n_chk = 0;
    int n_err = 0;
    logic [17:0] op_a[$];
    logic [17:0] op_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // gap < 0 picks a random 0..2 idle cycles between pairs.
    task automatic run_job(input int len, input bit sub, input int gap,
                           input bit poke_start, input string tag);
        longint unsigned sum;
        logic [63:0] neg;
        logic [47:0] exp_res;
        bit          exp_ovf;
        int          start_cyc, last_acc, budget, rv0, g;
        bit          seen_rdy;
        sum = 0;
        for (int i = 0; i < len; i++) sum += longint'(op_a[i]) * longint'(op_b[i]);
        neg     = 64'd0 - sum;
        exp_res = sub ? neg[47:0] : sum[47:0];
        exp_ovf = sub ? (sum != 0) : (sum >= (64'd1 << 48));

        rv0 = rv_total;
        START = 1'b1; LEN = LEN_W'(len); SUB = sub;
        start_cyc = cyc;
        last_acc  = cyc;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < len; i++) begin
            IN_A = op_a[i]; IN_B = op_b[i]; IN_VALID = 1'b1;
            budget = 0;
            while (!IN_READY && budget < 50) begin
                @(negedge CLK);
                budget++;
            end
            if (!IN_READY) begin
                check({tag, "_ready_timeout"}, 0, 1);
                IN_VALID = 1'b0;
                return;
            end
            last_acc = cyc;
            @(negedge CLK);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            IN_VALID = 1'b0;
            if (poke_start && i == 0) begin
                START = 1'b1; LEN = 8'd7; SUB = ~sub;
            end
            repeat (g) begin
                @(negedge CLK);
                START = 1'b0;
            end
            START = 1'b0;
        end

        budget = 0;
        seen_rdy = 1'b0;
        while (!RESULT_VALID && budget < 40) begin
            if (IN_READY) seen_rdy = 1'b1;
            @(negedge CLK);
            budget++;
        end
        check({tag, "_valid_seen"}, 64'(RESULT_VALID), 1);
        if (!RESULT_VALID) return;
        if (len == 0) begin
            check({tag, "_latency"}, 64'(cyc - start_cyc), 2);
            check({tag, "_ready_never"}, 64'(seen_rdy), 0);
        end else begin
            check({tag, "_latency"}, 64'(cyc - last_acc), 5);
        end
        check({tag, "_result"}, 64'(RESULT), 64'(exp_res));
        check({tag, "_ovf"}, 64'(OVF), 64'(exp_ovf));
        @(negedge CLK);
        check({tag, "_valid_pulse"}, 64'(RESULT_VALID), 0);
        check({tag, "_result_hold"}, 64'(RESULT), 64'(exp_res));
        repeat (3) @(negedge CLK);
        check({tag, "_idle_after"}, 64'(BUSY), 0);
        check({tag, "_one_strobe"}, 64'(rv_total - rv0), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, 64'(RESULT), 0);
        check({tag, "_valid"}, 64'(RESULT_VALID), 0);
        check({tag, "_busy"}, 64'(BUSY), 0);
        check({tag, "_ready"}, 64'(IN_READY), 0);
        check({tag, "_ovf"}, 64'(OVF), 0);
        check({tag, "_dsp_rst"}, 64'(DSP_RST), 1);
        check({tag, "_dsp_ce"}, 64'(DSP_CE), 0);
        check({tag, "_opmode"}, 64'(DSP_OPMODE), 0);
        check({tag, "_dsp_a"}, 64'(DSP_A), 0);
        check({tag, "_dsp_b"}, 64'(DSP_B), 0);
        check({tag, "_dsp_cd"}, {DSP_C, 16'(DSP_D[15:0])}, 0);
    endtask

    initial begin
        int rv0, acc, budget, len;
        RST_N = 1'b0; START = 1'b0; LEN = '0; SUB = 1'b0;
        IN_VALID = 1'b0; IN_A = '0; IN_B = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_release_hold", 64'(DSP_RST), 1);
        @(negedge CLK);
        check("rst_release_drop", 64'(DSP_RST), 0);

        op_a = '{18'd2, 18'd4, 18'd6}; op_b = '{18'd3, 18'd5, 18'd7};
        run_job(3, 1'b0, 0, 1'b0, "add");
        check("add_is_68", 64'(RESULT), 68);
        run_job(3, 1'b0, 2, 1'b1, "bubble");
        check("bubble_is_68", 64'(RESULT), 68);

        op_a = '{18'd1, 18'd2}; op_b = '{18'd1, 18'd2};
        run_job(2, 1'b1, 0, 1'b0, "sub");
        check("sub_value", 64'(RESULT), 64'h0000_FFFF_FFFF_FFFB);

        run_job(0, 1'b0, 0, 1'b0, "empty");

        op_a.delete(); op_b.delete();
        for (int i = 0; i < 255; i++) begin
            op_a.push_back(18'h3FFFF); op_b.push_back(18'h3FFFF);
        end
        run_job(255, 1'b0, 0, 1'b0, "full");
        check("full_value", 64'(RESULT), 64'd255 * ((64'd1 << 36) - (64'd1 << 19) + 64'd1));

        for (int j = 0; j < 6; j++) begin
            len = int'($urandom_range(1, 8));
            op_a.delete(); op_b.delete();
            for (int i = 0; i < len; i++) begin
                op_a.push_back(18'($urandom)); op_b.push_back(18'($urandom));
            end
            run_job(len, 1'($urandom), -1, 1'b0, $sformatf("rand%0d", j));
        end

        // Abandon a job with an asynchronous reset after two acceptances.
        rv0 = rv_total;
        START = 1'b1; LEN = 8'd4; SUB = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        IN_VALID = 1'b1; IN_A = 18'd5; IN_B = 18'd7;
        acc = 0; budget = 0;
        while (acc < 2 && budget < 50) begin
            if (IN_READY) acc++;
            @(negedge CLK);
            budget++;
        end
        check("midrst_accepts", 64'(acc), 2);
        IN_VALID = 1'b0;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_dsp_rst_hold", 64'(DSP_RST), 1);
        @(negedge CLK);
        check("midrst_no_strobe", 64'(rv_total - rv0), 0);
        op_a = '{18'd3}; op_b = '{18'd3};
        run_job(1, 1'b0, 0, 1'b0, "after_rst");
        check("after_rst_is_9", 64'(RESULT), 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles, want completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the job length.
REQ-002 SHALL drive a dsp48a1 instance configured as follows: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".
REQ-003 SHALL have one clock, CLK; reset is asynchronous and active-low, RST_N.
REQ-004 Ports (name, direction, width, meaning):
- CLK  in  1  clock.
- RST_N  in  1  async active-low reset.
- START  in  1  job request.
- LEN  in  LEN_W  number of operand pairs.
- SUB  in  1  1 = subtract products.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  operand pair accepted when both IN_VALID and IN_READY are high.
- IN_A  in  18  operand A.
- IN_B  in  18  operand B.
- BUSY  out  1  job in progress.
- RESULT  out  48  accumulated result.
- RESULT_VALID  out  1  one-cycle result strobe.
- OVF  out  1  sticky carry/borrow for the job.
- DSP_A  out  18  to DSP A port.
- DSP_B  out  18  to DSP B port.
- DSP_D  out  18  to DSP D port.
- DSP_C  out  48  to DSP C port.
- DSP_OPMODE  out  8  to DSP OPMODE port.
- DSP_CE  out  1  to all DSP CE inputs.
- DSP_RST  out  1  to all DSP RST inputs, active-high.
- DSP_P  in  48  from DSP P port.
- DSP_CARRYOUT  in  1  from DSP CARRYOUT port.

Function
REQ-005 SHALL implement four states: IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE transitions:
- START with LEN!=0: capture LEN and SUB, go to RUN.
- START with LEN=0: go to DONE with the result forced to 0.
- START is ignored in every state other than IDLE.
REQ-007 IN_READY SHALL be high only in RUN; each handshake decrements the remaining count; the last pair's handshake moves to DRAIN.
REQ-008 A pair accepted in cycle k SHALL appear on DSP_A/DSP_B in cycle k+1 (registered).
REQ-009 The OPMODE slot for that pair SHALL be driven on DSP_OPMODE in cycle k+2.
REQ-010 Every RUN cycle without a handshake SHALL produce a bubble slot with the same one-cycle offset.
REQ-011 DSP_OPMODE bit fields:
- bit7 = captured SUB.
- bits6:4 = 000 (no pre-adder, CIN=0).
- First accepted pair: Z=00, X=01.
- Later pairs: Z=10, X=01.
- Bubble: Z=10, X=00.
- Outside slots: 8'h00.
REQ-012 DRAIN SHALL last exactly 3 cycles, then DONE for 1 cycle.
REQ-013 In DONE, RESULT SHALL load DSP_P, or 0 for LEN=0; RESULT_VALID SHALL be high in cycle k+5 (k = last acceptance), and only for that cycle.
REQ-014 RESULT SHALL hold its value until the next DONE.
REQ-015 Arithmetic SHALL be unsigned 18x18 to 36-bit products, accumulated modulo 2^48.
REQ-016 SUB=1 SHALL yield 0 minus the sum of the products, modulo 2^48.
REQ-017 OVF SHALL clear on job start, then OR in DSP_CARRYOUT every cycle from (first acceptance + 4) through DONE; it is held until the next job starts.
REQ-018 BUSY SHALL be high in RUN, DRAIN and DONE; DSP_CE SHALL equal BUSY.
REQ-019 DSP_D and DSP_C SHALL be 0 at all times.

Reset
REQ-020 While RST_N is low, all outputs SHALL be 0 except DSP_RST=1, and the state SHALL be IDLE.
REQ-021 Reset asserted mid-job SHALL abandon the job immediately, with no RESULT_VALID.
REQ-022 DSP_RST SHALL stay high for the first CLK cycle after RST_N rises, so that no stale DSP pipeline content survives.

Verification
REQ-023 Add job: LEN=3, SUB=0, pairs (2,3),(4,5),(6,7) back-to-back -> RESULT=68, RESULT_VALID exactly 5 cycles after the 3rd acceptance, OVF=0.
REQ-024 Bubbles and blocked START: same job with IN_VALID low 2 cycles between pairs, plus START pulsed in RUN -> RESULT=68, latency from the last acceptance unchanged, second START ignored.
REQ-025 Subtract job: LEN=2, SUB=1, pairs (1,1),(2,2) -> RESULT=48'hFFFF_FFFF_FFFB, OVF=1.
REQ-026 Empty job: LEN=0 -> RESULT=0, RESULT_VALID 2 cycles after START, IN_READY never high.
REQ-027 Full-scale job: LEN=255, all pairs (18'h3FFFF,18'h3FFFF) -> RESULT=255*(2^36-2^19+1), OVF=0.
REQ-028 Reset mid-job: RST_N pulsed low after 2 acceptances of a LEN=4 job -> outputs at reset values; then LEN=1, pair (3,3) -> RESULT=9.
